true_dpr_be: RTL and testbench

Single-clock true dual-port RAM with per-byte write enables, a selectable read-during-write mode, an optional output pipeline register, and a post-reset clear sequencer. It supersedes the two-clock dual-port RAM for same-clock-domain users such as register files, descriptor tables and scratchpads. It adds deterministic write-write collision resolution and read-valid strobes.

---
 rtl/true_dpr_be_if.sv | 19 +
 rtl/true_dpr_be.sv | 178 +++++++++++++++++
 tb/tb_true_dpr_be.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/true_dpr_be_if.sv
// Single-port request/response bundle for true_dpr_be.
// The master drives the request; the slave (the RAM) returns read data and a valid strobe.
interface true_dpr_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  en;
    logic [NB-1:0]         we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] q;
    logic                  qvalid;

    modport master (output en, we, addr, data, input q, qvalid);
    modport slave  (input en, we, addr, data, output q, qvalid);
endinterface

// File: rtl/true_dpr_be.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write,
// optional output register and a post-reset clear sweep. Port A wins write-write collisions.
module true_dpr_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            init_done,
    true_dpr_be_if.slave    a_port,
    true_dpr_be_if.slave    b_port
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_init_done;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_a_acc, w_b_acc;
    logic [NB-1:0]         w_a_wr, w_b_wr;
    logic [DATA_WIDTH-1:0] w_a_old, w_b_old;
    logic [DATA_WIDTH-1:0] w_a_rd, w_b_rd;

    logic [DATA_WIDTH-1:0] r_a_q1, r_b_q1;
    logic                  r_a_v1, r_b_v1;

    // Overlay the byte lanes selected by we onto old_w.
    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         we
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = old_w[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    // Requests are honoured only once init_done is up, so clear-time traffic is dropped.
    assign w_a_acc = r_init_done & a_port.en;
    assign w_b_acc = r_init_done & b_port.en;
    assign w_a_wr  = w_a_acc ? a_port.we : {NB{1'b0}};
    assign w_b_wr  = w_b_acc ? b_port.we : {NB{1'b0}};

    // Reads see the pre-edge word, so the other port's same-cycle writes never leak in.
    assign w_a_old = r_mem[a_port.addr];
    assign w_b_old = r_mem[b_port.addr];
    assign w_a_rd  = (RDW_MODE != 0) ? f_merge(w_a_old, a_port.data, w_a_wr) : w_a_old;
    assign w_b_rd  = (RDW_MODE != 0) ? f_merge(w_b_old, b_port.data, w_b_wr) : w_b_old;

    // Clear sequencer: sweep every word once after reset, then stay ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_cnt       <= {ADDR_WIDTH{1'b0}};
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                        r_state     <= S_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_done <= 1'b0;
                    end
                end
                S_READY: begin
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= S_CLEAR;
                    r_cnt       <= {ADDR_WIDTH{1'b0}};
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; port A lanes are written last so they win a same-lane collision.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= {DATA_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (w_b_wr[i]) begin
                    r_mem[b_port.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_port.data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (w_a_wr[i]) begin
                    r_mem[a_port.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_port.data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // First read stage: capture data on accepted requests, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q1 <= {DATA_WIDTH{1'b0}};
            r_b_q1 <= {DATA_WIDTH{1'b0}};
            r_a_v1 <= 1'b0;
            r_b_v1 <= 1'b0;
        end else begin
            r_a_v1 <= w_a_acc;
            r_b_v1 <= w_b_acc;
            if (w_a_acc) begin
                r_a_q1 <= w_a_rd;
            end else begin
                r_a_q1 <= r_a_q1;
            end
            if (w_b_acc) begin
                r_b_q1 <= w_b_rd;
            end else begin
                r_b_q1 <= r_b_q1;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] r_a_q2, r_b_q2;
            logic                  r_a_v2, r_b_v2;

            // Second read stage: forward stage-one results, holding data between them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_q2 <= {DATA_WIDTH{1'b0}};
                    r_b_q2 <= {DATA_WIDTH{1'b0}};
                    r_a_v2 <= 1'b0;
                    r_b_v2 <= 1'b0;
                end else begin
                    r_a_v2 <= r_a_v1;
                    r_b_v2 <= r_b_v1;
                    if (r_a_v1) begin
                        r_a_q2 <= r_a_q1;
                    end else begin
                        r_a_q2 <= r_a_q2;
                    end
                    if (r_b_v1) begin
                        r_b_q2 <= r_b_q1;
                    end else begin
                        r_b_q2 <= r_b_q2;
                    end
                end
            end

            assign a_port.q      = r_a_q2;
            assign a_port.qvalid = r_a_v2;
            assign b_port.q      = r_b_q2;
            assign b_port.qvalid = r_b_v2;
        end else begin : g_noreg
            assign a_port.q      = r_a_q1;
            assign a_port.qvalid = r_a_v1;
            assign b_port.q      = r_b_q1;
            assign b_port.qvalid = r_b_v1;
        end
    endgenerate

    assign init_done = r_init_done;

endmodule

// File: tb/tb_true_dpr_be.sv
// Scoreboard bench for true_dpr_be: two instances (READ_FIRST/latency 1 and
// WRITE_FIRST/latency 2) share one random stimulus stream and one array model.
module tb_true_dpr_be;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init0, init1;

    logic          a_en, b_en;
    logic [3:0]    a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;

    int cyc = 0;
    int rel_cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    logic [DW-1:0] mem_m [DEPTH];
    exp_t          sb [4][$];
    logic [DW-1:0] last_q [4];
    logic [DW-1:0] q_s [4];
    logic          v_s [4];

    true_dpr_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) if0a ();
    true_dpr_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) if0b ();
    true_dpr_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) if1a ();
    true_dpr_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW)) if1b ();

    assign if0a.en = a_en;  assign if0a.we = a_we;  assign if0a.addr = a_addr;  assign if0a.data = a_data;
    assign if1a.en = a_en;  assign if1a.we = a_we;  assign if1a.addr = a_addr;  assign if1a.data = a_data;
    assign if0b.en = b_en;  assign if0b.we = b_we;  assign if0b.addr = b_addr;  assign if0b.data = b_data;
    assign if1b.en = b_en;  assign if1b.we = b_we;  assign if1b.addr = b_addr;  assign if1b.data = b_data;

    assign q_s[0] = if0a.q;  assign v_s[0] = if0a.qvalid;
    assign q_s[1] = if0b.q;  assign v_s[1] = if0b.qvalid;
    assign q_s[2] = if1a.q;  assign v_s[2] = if1a.qvalid;
    assign q_s[3] = if1b.q;  assign v_s[3] = if1b.qvalid;

    true_dpr_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
                  .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_done(init0), .a_port(if0a), .b_port(if0b));

    true_dpr_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
                  .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(init1), .a_port(if1a), .b_port(if1b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] we);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    // Drive one cycle of requests and record what each instance must return.
    task automatic issue(input logic ae, input logic [3:0] awe, input logic [AW-1:0] aad,
                         input logic [DW-1:0] ad, input logic be, input logic [3:0] bwe,
                         input logic [AW-1:0] bad, input logic [DW-1:0] bd);
        logic [DW-1:0] old_a, old_b;
        @(negedge clk);
        a_en = ae; a_we = awe; a_addr = aad; a_data = ad;
        b_en = be; b_we = bwe; b_addr = bad; b_data = bd;
        if (rst_n && (cyc - rel_cyc) >= DEPTH) begin
            old_a = mem_m[aad];
            old_b = mem_m[bad];
            if (ae) begin
                sb[0].push_back('{d: old_a, due: cyc + 1});
                sb[2].push_back('{d: merge(old_a, ad, awe), due: cyc + 2});
            end
            if (be) begin
                sb[1].push_back('{d: old_b, due: cyc + 1});
                sb[3].push_back('{d: merge(old_b, bd, bwe), due: cyc + 2});
            end
            if (be) mem_m[bad] = merge(mem_m[bad], bd, bwe);
            if (ae) mem_m[aad] = merge(mem_m[aad], ad, awe);
        end
    endtask

    task automatic issue_idle();
        issue(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic issue_rand();
        issue($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    endtask

    task automatic assert_rst();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        a_en = 1'b0;
        b_en = 1'b0;
        for (int c = 0; c < 4; c++) sb[c].delete();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
        end
    endtask

    // Monitor: compare every presented result with the oldest expectation for that channel.
    always @(negedge clk) begin
        exp_t e;
        logic exp_init;
        if (!rst_n) begin
            n_checks++;
            if (init0 !== 1'b0 || init1 !== 1'b0) begin
                n_err++;
                $display("FAIL reset_init got %b/%b want 0/0", init0, init1);
            end
            for (int c = 0; c < 4; c++) begin
                n_checks++;
                if (v_s[c] !== 1'b0 || q_s[c] !== 32'h0) begin
                    n_err++;
                    $display("FAIL reset_out ch%0d got q=%h v=%b want q=0 v=0", c, q_s[c], v_s[c]);
                end
                last_q[c] = 32'h0;
            end
        end else begin
            exp_init = (cyc - rel_cyc) >= DEPTH;
            n_checks++;
            if (init0 !== exp_init || init1 !== exp_init) begin
                n_err++;
                $display("FAIL init_done cyc%0d got %b/%b want %b", cyc - rel_cyc, init0, init1, exp_init);
            end
            for (int c = 0; c < 4; c++) begin
                if (v_s[c] === 1'b1) begin
                    n_checks++;
                    if (sb[c].size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_valid ch%0d got q=%h want no valid", c, q_s[c]);
                    end else begin
                        e = sb[c].pop_front();
                        if (e.due != cyc || q_s[c] !== e.d) begin
                            n_err++;
                            $display("FAIL read ch%0d got q=%h at cyc %0d want %h at cyc %0d",
                                     c, q_s[c], cyc, e.d, e.due);
                        end
                        last_q[c] = e.d;
                    end
                end else begin
                    n_checks++;
                    if (v_s[c] !== 1'b0 || q_s[c] !== last_q[c]) begin
                        n_err++;
                        $display("FAIL hold ch%0d got q=%h v=%b want q=%h v=0", c, q_s[c], v_s[c], last_q[c]);
                    end
                    if (sb[c].size() > 0 && sb[c][0].due <= cyc) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL missing_valid ch%0d got none want %h at cyc %0d", c, sb[c][0].d, sb[c][0].due);
                        void'(sb[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        a_en = 1'b0; a_we = 4'h0; a_addr = 4'h0; a_data = 32'h0;
        b_en = 1'b0; b_we = 4'h0; b_addr = 4'h0; b_data = 32'h0;
        repeat (3) issue_rand();

        // Clear sweep: traffic during the sweep is dropped, first ready-cycle reads are accepted.
        release_rst();
        repeat (DEPTH - 1) issue_rand();
        read_all();

        // Byte enables, then read on port B.
        issue(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0);
        issue(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0);
        issue(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);

        // Same-port read-during-write on a zero word.
        issue(1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0, 4'h0, 4'd0, 32'h0);

        // Cross-port collision, then read back on both ports.
        issue(1'b1, 4'b0011, 4'd7, 32'hAAAAAAAA, 1'b1, 4'b0110, 4'd7, 32'hBBBBBBBB);
        issue(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
        issue_idle();

        // Back-to-back reads of addresses 0..3 on port A.
        for (int i = 0; i < 4; i++) issue(1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);

        repeat (300) issue_rand();

        // Async reset with results in flight, then a reset in the middle of the clear sweep.
        assert_rst();
        repeat (2) issue_rand();
        release_rst();
        repeat (9) issue_rand();
        assert_rst();
        repeat (2) issue_rand();
        release_rst();
        repeat (DEPTH - 1) issue_rand();
        read_all();

        repeat (100) issue_rand();
        repeat (5) issue_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
